// File: rtl/counter_pkg.sv
// Shared types and elaboration helpers for the BCD/modulo counter chain.
// Imported by the digit, the chain top and its interface.
package counter_pkg;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DOWN
  } step_e;

  function automatic int dw_of(input int radix);
    return (radix <= 2) ? 1 : $clog2(radix);
  endfunction

  function automatic bit params_ok(
    input int digits,
    input int radix
  );
    return (digits >= 1) && (radix >= 2) && (radix <= 16);
  endfunction

endpackage

// File: rtl/bcd_counter_chain_if.sv
// Command/status bundle between a counter chain and its driver.
// Digit i of load_val/out sits at bits [i*DW +: DW].
interface bcd_counter_chain_if
  import counter_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10
);
  localparam int DW = dw_of(RADIX);

  logic                 clear;
  logic                 load;
  logic [DIGITS*DW-1:0] load_val;
  logic                 inc;
  logic                 dec;
  logic                 wrap_en;
  logic [DIGITS*DW-1:0] out;
  logic                 carry_out;
  logic                 borrow_out;
  logic                 overflow;
  logic                 load_err;

  modport master (
    output clear, load, load_val,
    output inc, dec, wrap_en,
    input  out, carry_out, borrow_out,
    input  overflow, load_err
  );

  modport slave (
    input  clear, load, load_val,
    input  inc, dec, wrap_en,
    output out, carry_out, borrow_out,
    output overflow, load_err
  );

endinterface

// File: rtl/bcd_digit.sv
// One modulo-RADIX digit: clear, clamped load, and enabled up/down step
// that rolls over at the ends. Saturation is decided by the chain.
module bcd_digit
  import counter_pkg::*;
#(
  parameter  int RADIX = 10,
  localparam int DW    = dw_of(RADIX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load,
  input  logic [DW-1:0] ld_digit,
  input  step_e         step,
  input  logic          en,
  output logic [DW-1:0] q,
  output logic          at_max,
  output logic          at_zero
);

  localparam logic [DW-1:0] MAX = DW'(RADIX - 1);

  logic [DW-1:0] q_q;
  logic [DW-1:0] q_d;

  assign at_max  = (q_q == MAX);
  assign at_zero = (q_q == '0);
  assign q       = q_q;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = (ld_digit > MAX) ? MAX : ld_digit;
    end else if (en) begin
      unique case (step)
        STEP_UP:   q_d = at_max  ? '0  : q_q + DW'(1);
        STEP_DOWN: q_d = at_zero ? MAX : q_q - DW'(1);
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/bcd_counter_chain.sv
// Multi-digit modulo-RADIX counter: step decode, carry/borrow prefix
// chains, end-of-range wrap/saturate, sticky overflow, load_err pulse.
module bcd_counter_chain
  import counter_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10
) (
  input logic                 clk,
  input logic                 rst_n,
  bcd_counter_chain_if.slave  bus
);

  localparam int DW = dw_of(RADIX);

  if (!params_ok(DIGITS, RADIX)) begin : g_bad_params
    $error("bcd_counter_chain: DIGITS>=1, RADIX in 2..16");
  end

  step_e             step;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;
  logic [DIGITS-1:0] up_pre;
  logic [DIGITS-1:0] dn_pre;
  logic [DIGITS-1:0] en;
  logic              all_max;
  logic              all_zero;
  logic              term;
  logic              sat;
  logic              any_clamp;
  logic              overflow_q, overflow_d;
  logic              load_err_q, load_err_d;

  always_comb begin
    step = STEP_HOLD;
    if (!bus.clear && !bus.load) begin
      if (bus.inc && !bus.dec)      step = STEP_UP;
      else if (bus.dec && !bus.inc) step = STEP_DOWN;
    end
  end

  // Digit i moves only when every lower digit is about to roll over.
  always_comb begin
    up_pre    = '0;
    dn_pre    = '0;
    up_pre[0] = 1'b1;
    dn_pre[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      up_pre[i] = up_pre[i-1] & at_max[i-1];
      dn_pre[i] = dn_pre[i-1] & at_zero[i-1];
    end
  end

  assign all_max  = &at_max;
  assign all_zero = &at_zero;
  assign term     = ((step == STEP_UP) && all_max)
                 || ((step == STEP_DOWN) && all_zero);
  assign sat      = term && !bus.wrap_en;

  always_comb begin
    any_clamp = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[i*DW +: DW] > DW'(RADIX - 1)) any_clamp = 1'b1;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign en[i] = !sat
      && (((step == STEP_UP)   && up_pre[i])
       || ((step == STEP_DOWN) && dn_pre[i]));

    bcd_digit #(.RADIX(RADIX)) u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (bus.clear),
      .load     (bus.load),
      .ld_digit (bus.load_val[i*DW +: DW]),
      .step     (step),
      .en       (en[i]),
      .q        (bus.out[i*DW +: DW]),
      .at_max   (at_max[i]),
      .at_zero  (at_zero[i])
    );
  end

  assign bus.carry_out  = bus.inc && !bus.dec && all_max
                       && !bus.clear && !bus.load;
  assign bus.borrow_out = bus.dec && !bus.inc && all_zero
                       && !bus.clear && !bus.load;

  always_comb begin
    overflow_d = overflow_q;
    load_err_d = 1'b0;
    if (bus.clear) begin
      overflow_d = 1'b0;
    end else if (bus.load) begin
      load_err_d = any_clamp;
    end else if (term) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.overflow = overflow_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Scoreboard bench: a 4x10 chain and a 2x6 chain checked against an
// integer reference model of count, overflow and load_err.
module tb_bcd_counter_chain;

  typedef struct {
    int val;
    bit ovf;
    bit lerr;
  } st_t;

  typedef struct {
    logic [31:0] out;
    logic        ovf;
    logic        lerr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  st_t  sa, sb;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  bcd_counter_chain_if #(.DIGITS(4), .RADIX(10)) ia ();
  bcd_counter_chain_if #(.DIGITS(2), .RADIX(6))  ib ();

  bcd_counter_chain #(.DIGITS(4), .RADIX(10)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia.slave)
  );

  bcd_counter_chain #(.DIGITS(2), .RADIX(6)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib.slave)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(
    input int v, input int digits, input int radix, input int dw
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r |= 32'(v % radix) << (i * dw);
      v = v / radix;
    end
    return r;
  endfunction

  function automatic int unpack_clamp(
    input  logic [31:0] lv,
    input  int digits, input int radix, input int dw,
    output bit err
  );
    int val, mult, d;
    val  = 0;
    mult = 1;
    err  = 1'b0;
    for (int i = 0; i < digits; i++) begin
      d = int'((lv >> (i * dw)) & ((32'd1 << dw) - 1));
      if (d >= radix) begin
        d   = radix - 1;
        err = 1'b1;
      end
      val  += d * mult;
      mult *= radix;
    end
    return val;
  endfunction

  function automatic st_t mstep(
    input st_t s, input bit c, input bit l, input logic [31:0] lv,
    input bit i, input bit d, input bit w,
    input int digits, input int radix, input int dw
  );
    st_t n;
    int  mx;
    bit  e;
    mx = radix ** digits - 1;
    n  = s;
    n.lerr = 1'b0;
    if (c) begin
      n = '{0, 1'b0, 1'b0};
    end else if (l) begin
      n.val  = unpack_clamp(lv, digits, radix, dw, e);
      n.lerr = e;
    end else if (i && !d) begin
      if (s.val == mx) begin
        n.ovf = 1'b1;
        n.val = w ? 0 : mx;
      end else n.val = s.val + 1;
    end else if (d && !i) begin
      if (s.val == 0) begin
        n.ovf = 1'b1;
        n.val = w ? mx : 0;
      end else n.val = s.val - 1;
    end
    return n;
  endfunction

  task automatic drive_a(
    input bit c, input bit l, input logic [31:0] lv,
    input bit i, input bit d, input bit w
  );
    exp_t e;
    ia.clear = c; ia.load = l; ia.load_val = lv[15:0];
    ia.inc = i; ia.dec = d; ia.wrap_en = w;
    #1;
    chk("a_carry", 32'(ia.carry_out),
        32'(i && !d && !c && !l && sa.val == 9999));
    chk("a_borrow", 32'(ia.borrow_out),
        32'(d && !i && !c && !l && sa.val == 0));
    sa = mstep(sa, c, l, lv, i, d, w, 4, 10, 4);
    qa.push_back('{pack(sa.val, 4, 10, 4), sa.ovf, sa.lerr});
    @(posedge clk);
    #1;
    e = qa.pop_front();
    chk("a_out", ia.out, e.out);
    chk("a_ovf", 32'(ia.overflow), 32'(e.ovf));
    chk("a_lerr", 32'(ia.load_err), 32'(e.lerr));
    ia.clear = 0; ia.load = 0; ia.inc = 0; ia.dec = 0;
  endtask

  task automatic drive_b(
    input bit c, input bit l, input logic [31:0] lv,
    input bit i, input bit d, input bit w
  );
    exp_t e;
    ib.clear = c; ib.load = l; ib.load_val = lv[5:0];
    ib.inc = i; ib.dec = d; ib.wrap_en = w;
    #1;
    chk("b_carry", 32'(ib.carry_out),
        32'(i && !d && !c && !l && sb.val == 35));
    chk("b_borrow", 32'(ib.borrow_out),
        32'(d && !i && !c && !l && sb.val == 0));
    sb = mstep(sb, c, l, lv, i, d, w, 2, 6, 3);
    qb.push_back('{pack(sb.val, 2, 6, 3), sb.ovf, sb.lerr});
    @(posedge clk);
    #1;
    e = qb.pop_front();
    chk("b_out", ib.out, e.out);
    chk("b_ovf", 32'(ib.overflow), 32'(e.ovf));
    chk("b_lerr", 32'(ib.load_err), 32'(e.lerr));
    ib.clear = 0; ib.load = 0; ib.inc = 0; ib.dec = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    ia.clear = 0; ia.load = 0; ia.load_val = '0;
    ia.inc = 0; ia.dec = 0; ia.wrap_en = 1;
    ib.clear = 0; ib.load = 0; ib.load_val = '0;
    ib.inc = 0; ib.dec = 0; ib.wrap_en = 1;
    sa = '{0, 1'b0, 1'b0};
    sb = '{0, 1'b0, 1'b0};
    #2;
    chk("rst_a_out", ia.out, 32'h0);
    chk("rst_a_ovf", 32'(ia.overflow), 32'h0);
    chk("rst_a_lerr", 32'(ia.load_err), 32'h0);
    chk("rst_b_out", ib.out, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (500) drive_a(0, 0, 0, 1, 0, 1);
    chk("a_500", ia.out, 32'h0500);
    #3 rst_n = 1'b0;
    #1 chk("rst_mid", ia.out, 32'h0);
    sa = '{0, 1'b0, 1'b0};
    @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (1234) drive_a(0, 0, 0, 1, 0, 1);
    chk("a_1234", ia.out, 32'h1234);

    drive_a(0, 1, 32'h0999, 0, 0, 1);
    drive_a(0, 0, 0, 1, 0, 1);
    chk("a_1000", ia.out, 32'h1000);
    drive_a(0, 0, 0, 0, 1, 1);

    drive_a(0, 1, 32'h9999, 0, 0, 1);
    drive_a(0, 0, 0, 1, 0, 1);
    drive_a(1, 0, 0, 0, 0, 1);
    drive_a(0, 1, 32'h9999, 0, 0, 0);
    drive_a(0, 0, 0, 1, 0, 0);
    drive_a(1, 0, 0, 0, 0, 0);

    drive_a(0, 1, 32'h0000, 0, 0, 0);
    drive_a(0, 0, 0, 0, 1, 0);
    drive_a(0, 0, 0, 0, 0, 0);
    drive_a(1, 0, 0, 0, 0, 0);

    drive_a(0, 1, 32'h1A2F, 0, 0, 1);
    chk("a_clamp", ia.out, 32'h1929);
    drive_a(0, 0, 0, 0, 0, 1);

    drive_a(0, 1, 32'h0777, 0, 0, 1);
    drive_a(1, 1, 32'h0555, 1, 0, 1);
    drive_a(0, 1, 32'h0005, 1, 0, 1);
    drive_a(0, 1, 32'h0042, 0, 0, 1);
    drive_a(0, 0, 0, 1, 1, 1);
    drive_a(0, 0, 0, 0, 1, 1);

    repeat (35) drive_b(0, 0, 0, 1, 0, 1);
    chk("b_55", ib.out, 32'o55);
    drive_b(0, 0, 0, 1, 0, 1);
    drive_b(0, 1, 32'o10, 0, 0, 1);
    drive_b(0, 0, 0, 0, 1, 1);
    chk("b_05", ib.out, 32'o05);
    drive_b(0, 1, 32'o77, 0, 0, 1);
    drive_b(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
